// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns a MEM-stage load/store into a single
// word-aligned memory transaction, stalling the pipeline until it completes or times out.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] BE_WD,
  input  logic [3:0]  byte_enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] RD,
  output logic        stallM,
  output logic        misalign,
  output logic        bus_err,
  output logic [1:0]  dbg_state_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [31:0]      rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             berr_q, berr_d;

  logic req_any;
  logic is_half;
  logic is_word;
  logic mis_req;
  logic access;
  logic stall_raw;
  logic req_raw;
  logic unused_f3_sign;

  // Bit 2 of funct3 only selects load sign extension, which happens downstream.
  assign unused_f3_sign = funct3M[2];

  assign req_any = MemReadM | MemWriteM;
  assign is_half = (funct3M[1:0] == 2'b01);
  assign is_word = funct3M[1];
  assign mis_req = (is_half & AddrM[0]) | (is_word & (AddrM[1:0] != 2'b00));
  assign access  = req_any & ~mis_req;

  // Handshake: mem_req is valid for every BUSY cycle with mem_addr/mem_we/mem_be/
  // mem_wdata held stable; mem_ready is the completion and is honoured only in BUSY.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    stall_raw = 1'b0;
    req_raw   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d    = {AddrM[31:2], 2'b00};
          wdata_d   = BE_WD;
          we_d      = MemWriteM;
          be_d      = MemWriteM ? byte_enable : 4'b1111;
          cnt_d     = '0;
          stall_raw = 1'b1;
          state_d   = S_BUSY;
        end else if (req_any) begin
          mis_d = 1'b1;
        end
      end
      S_BUSY: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (mem_ready) begin
          if (!we_q) begin
            rd_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // One dead cycle lets the pipeline advance before a new request is sampled.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      we_q    <= 1'b0;
      rd_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  // The stall is combinational from the request, so mask it while reset is held.
  assign stallM      = stall_raw & n_rst;
  assign mem_req     = req_raw;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign RD          = rd_q;
  assign misalign    = mis_q;
  assign bus_err     = berr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares them whenever the DUT presents an event.
module tb_dmem_access_ctrl;

  localparam int TMO = 16;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] AddrM, BE_WD;
  logic [3:0]  byte_enable;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] RD;
  logic        stallM, misalign, bus_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .AddrM(AddrM), .BE_WD(BE_WD), .byte_enable(byte_enable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .RD(RD),
    .stallM(stallM), .misalign(misalign), .bus_err(bus_err), .dbg_state_o(dbg_state)
  );

  logic [68:0] exp_req_q[$];   // {we, be, addr, wdata} at request start
  logic [34:0] exp_done_q[$];  // {bus_err, mem_req, stallM, RD} in the DONE cycle
  logic [35:0] exp_ctl_q[$];   // {mem_req, stallM, misalign, bus_err, RD} snapshot
  logic [68:0] exp_lat_q[$];   // {we, be, addr, wdata} snapshot
  logic [1:0]  exp_mis_q[$];   // {mem_req, stallM} during a misalign pulse
  int          exp_stall_q[$];
  int          exp_busy_q[$];
  int          exp_gap_q[$];

  int          checks = 0;
  int          failures = 0;
  int          drv_errs = 0;
  logic        tb_done = 1'b0;
  logic [31:0] rd_model = 32'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // Monitor / scoreboard
  initial begin
    logic        req_prev;
    logic [68:0] req_hold;
    logic [68:0] cur;
    int          stall_run, busy_run, low_run;
    req_prev = 1'b0; req_hold = '0;
    stall_run = 0; busy_run = 0; low_run = 0;
    forever begin
      @(negedge clk);
      cur = {mem_we, mem_be, mem_addr, mem_wdata};
      if (exp_ctl_q.size() != 0)
        check("ctl_snapshot", 128'({mem_req, stallM, misalign, bus_err, RD}), 128'(exp_ctl_q.pop_front()));
      if (exp_lat_q.size() != 0)
        check("latched_fields", 128'(cur), 128'(exp_lat_q.pop_front()));
      if (mem_req && !req_prev) begin
        if (exp_gap_q.size() != 0) check("req_gap", 128'(low_run), 128'(exp_gap_q.pop_front()));
        if (exp_req_q.size() == 0) note_fail("unexpected_req", 128'(cur));
        else check("req_fields", 128'(cur), 128'(exp_req_q.pop_front()));
        req_hold = cur;
        low_run = 0;
      end else if (mem_req) begin
        check("req_stable", 128'(cur), 128'(req_hold));
      end else begin
        low_run++;
      end
      if (stallM) stall_run++;
      else if (stall_run != 0) begin
        if (exp_stall_q.size() != 0) check("stall_cycles", 128'(stall_run), 128'(exp_stall_q.pop_front()));
        stall_run = 0;
      end
      if (mem_req) busy_run++;
      else if (busy_run != 0) begin
        if (exp_busy_q.size() != 0) check("busy_cycles", 128'(busy_run), 128'(exp_busy_q.pop_front()));
        busy_run = 0;
      end
      if (dbg_state == ST_DONE) begin
        if (exp_done_q.size() == 0) note_fail("unexpected_done", 128'({bus_err, RD}));
        else check("done", 128'({bus_err, mem_req, stallM, RD}), 128'(exp_done_q.pop_front()));
      end else if (bus_err) begin
        note_fail("bus_err_outside_done", 128'(dbg_state));
      end
      if (misalign) begin
        if (exp_mis_q.size() == 0) note_fail("unexpected_misalign", 128'(AddrM));
        else check("misalign_ctl", 128'({mem_req, stallM}), 128'(exp_mis_q.pop_front()));
      end
      req_prev = mem_req;
      if (tb_done) begin
        check("left_req", 128'(exp_req_q.size()), 128'(0));
        check("left_done", 128'(exp_done_q.size()), 128'(0));
        check("left_mis", 128'(exp_mis_q.size() + exp_ctl_q.size() + exp_lat_q.size()), 128'(0));
        check("left_runs", 128'(exp_stall_q.size() + exp_busy_q.size() + exp_gap_q.size()), 128'(0));
        check("driver_timeouts", 128'(drv_errs), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Issue one aligned access; ready_k = BUSY cycle carrying mem_ready (0 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int ready_k, input logic [31:0] rdata);
    int k;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; AddrM = addr;
    BE_WD = wdata; byte_enable = be; mem_ready = 1'b0;
    @(posedge clk); #1;
    k = 1;
    while (dbg_state == ST_BUSY && k <= TMO + 4) begin
      mem_ready = (k == ready_k);
      mem_rdata = rdata;
      @(posedge clk); #1;
      k++;
    end
    if (dbg_state != ST_DONE) drv_errs++;
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_mis(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; AddrM = addr;
    exp_ctl_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, rd_model});
    exp_mis_q.push_back(2'b00);
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int nb, nd;
    n_rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    AddrM = '0; BE_WD = '0; byte_enable = '0; mem_rdata = '0; mem_ready = 1'b0;
    exp_ctl_q.push_back(36'h0);
    exp_lat_q.push_back(69'h0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Word load, ready on 2nd BUSY cycle
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0104, 32'h0});
    exp_done_q.push_back({3'b000, 32'hCAFE_F00D});
    exp_stall_q.push_back(3); exp_busy_q.push_back(2);
    run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 2, 32'hCAFE_F00D);
    rd_model = 32'hCAFE_F00D;

    // Byte store at 0x203, minimum latency, RD must not change
    exp_req_q.push_back({1'b1, 4'b1000, 32'h0000_0200, 32'hAB00_0000});
    exp_done_q.push_back({3'b000, rd_model});
    exp_stall_q.push_back(2); exp_busy_q.push_back(1);
    run_access(1'b0, 1'b1, 3'b000, 32'h203, 32'hAB00_0000, 4'b1000, 1, 32'h1234_5678);

    // Unsigned byte load at an odd address is aligned
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0104, 32'h0});
    exp_done_q.push_back({3'b000, 32'h0BAD_F00D});
    exp_stall_q.push_back(4); exp_busy_q.push_back(3);
    run_access(1'b1, 1'b0, 3'b100, 32'h107, 32'h0, 4'h0, 3, 32'h0BAD_F00D);
    rd_model = 32'h0BAD_F00D;

    // funct3=110 behaves as word; read+write together is a write
    exp_req_q.push_back({1'b1, 4'b1111, 32'h0000_0108, 32'h0123_4567});
    exp_done_q.push_back({3'b000, rd_model});
    exp_stall_q.push_back(2); exp_busy_q.push_back(1);
    run_access(1'b1, 1'b1, 3'b110, 32'h108, 32'h0123_4567, 4'b1111, 1, 32'hFFFF_FFFF);

    // Misaligned requests
    run_mis(1'b1, 1'b0, 3'b001, 32'h101);
    run_mis(1'b1, 1'b0, 3'b010, 32'h102);
    run_mis(1'b0, 1'b1, 3'b111, 32'h003);
    run_mis(1'b1, 1'b0, 3'b101, 32'h203);

    // Timeout: never ready
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0300, 32'h0});
    exp_done_q.push_back({3'b100, rd_model});
    exp_stall_q.push_back(TMO + 1); exp_busy_q.push_back(TMO);
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 4'h0, 0, 32'h7777_7777);

    // Ready on the last BUSY cycle beats the timeout
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0304, 32'h0});
    exp_done_q.push_back({3'b000, 32'h5555_AAAA});
    exp_stall_q.push_back(TMO + 1); exp_busy_q.push_back(TMO);
    run_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 4'h0, TMO, 32'h5555_AAAA);
    rd_model = 32'h5555_AAAA;

    // Reset in the 3rd BUSY cycle, then a late mem_ready
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0400, 32'h0});
    @(posedge clk); #1;
    MemReadM = 1'b1; funct3M = 3'b010; AddrM = 32'h400; BE_WD = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    n_rst = 1'b0; MemReadM = 1'b0;
    rd_model = 32'h0;
    exp_ctl_q.push_back(36'h0);
    exp_lat_q.push_back(69'h0);
    @(posedge clk); #1;
    n_rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    exp_ctl_q.push_back({4'b0000, rd_model});
    @(posedge clk); #1;
    mem_ready = 1'b0;

    // Back-to-back loads held across DONE; the gap is DONE plus the re-issue IDLE cycle
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0500, 32'h0});
    exp_req_q.push_back({1'b0, 4'b1111, 32'h0000_0500, 32'h0});
    exp_done_q.push_back({3'b000, 32'h1111_1111});
    exp_done_q.push_back({3'b000, 32'h2222_2222});
    exp_stall_q.push_back(2); exp_stall_q.push_back(2);
    exp_busy_q.push_back(1); exp_busy_q.push_back(1);
    @(posedge clk); #1;
    MemReadM = 1'b1; funct3M = 3'b010; AddrM = 32'h500;
    nb = 0; nd = 0;
    for (int c = 0; c < 12 && nd < 2; c++) begin
      @(posedge clk); #1;
      if (dbg_state == ST_BUSY) begin
        nb++;
        mem_ready = 1'b1;
        mem_rdata = (nb == 1) ? 32'h1111_1111 : 32'h2222_2222;
      end else begin
        mem_ready = 1'b0;
      end
      if (dbg_state == ST_DONE) begin
        nd++;
        if (nd == 1) exp_gap_q.push_back(2);
      end
    end
    if (nd != 2) drv_errs++;
    MemReadM = 1'b0; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    tb_done = 1'b1;
  end

endmodule
